segment_display: RTL and testbench

SEGMENT_DISPLAY -- requirements
Module: segment_display

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_font.sv | 16 +
 rtl/segment_display.sv | 124 ++++++++++++
 tb/tb_segment_display.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 4-digit seven-segment driver.
// Holds the scan FSM state type, the active-low hex font and default timing values.
// No logic here; imported by the display top and the font decoder.
package seg_pkg;

  // Default timing at a 100 MHz clock
  localparam int REFRESH_DIV_DEF = 100000;
  localparam int DEAD_CYCLES_DEF = 1000;
  localparam int BLINK_DIV_DEF   = 25000000;

  // Scan FSM: all anodes dark, or one digit driven
  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  // Active-low {g,f,e,d,c,b,a} patterns; index 0 is the rightmost entry
  localparam logic [15:0][6:0] FONT_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  function automatic logic [6:0] font_lookup(input logic [3:0] nibble);
    return FONT_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg_font.sv
// Hex nibble to active-low seven-segment pattern decoder.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module seg_font
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Table lookup of the glyph for the selected digit
  always_comb begin
    pattern = font_lookup(nibble);
  end

endmodule

// File: rtl/segment_display.sv
// Time-multiplexed 4-digit seven-segment driver with dead time and per-digit blink.
// Latency: seg/an are registered, one cycle behind scan state and shadow registers.
// Backpressure: none; load is a fire-and-forget strobe into shadow registers.
module segment_display
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int BLINK_DIV   = BLINK_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  en_in,
  input  logic [3:0]  blink_in,
  input  logic        load,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam logic [31:0] SHOW_LEN  = 32'(REFRESH_DIV);
  localparam logic [31:0] BLANK_LEN = 32'(DEAD_CYCLES);
  localparam logic [31:0] BLINK_MAX = 32'(BLINK_DIV - 1);

  // Shadow copies of the display request
  logic [15:0] dig_q;
  logic [3:0]  dp_q;
  logic [3:0]  en_q;
  logic [3:0]  blink_q;

  // Scan timing
  scan_state_t state_q;
  logic [1:0]  idx_q;
  logic [31:0] scan_cnt_q;

  // Free-running blink timebase
  logic [31:0] blink_cnt_q;
  logic        blink_phase_q;

  // Next-output decode
  logic [3:0]  cur_nib;
  logic [6:0]  font_pat;
  logic        lit;
  logic [7:0]  seg_nxt;
  logic [3:0]  an_nxt;

  // Capture the request only on a load strobe; later loads overwrite earlier ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q   <= '0;
      dp_q    <= '0;
      en_q    <= '0;
      blink_q <= '0;
    end else if (load) begin
      dig_q   <= digits_in;
      dp_q    <= dp_in;
      en_q    <= en_in;
      blink_q <= blink_in;
    end
  end

  // Scan sequencer: each state counts down its own length, idx advances leaving SHOW
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      idx_q      <= 2'd0;
      scan_cnt_q <= BLANK_LEN;
    end else if (scan_cnt_q == 32'd1) begin
      if (state_q == ST_BLANK) begin
        state_q    <= ST_SHOW;
        scan_cnt_q <= SHOW_LEN;
      end else begin
        state_q    <= ST_BLANK;
        idx_q      <= idx_q + 2'd1;
        scan_cnt_q <= BLANK_LEN;
      end
    end else begin
      scan_cnt_q <= scan_cnt_q - 32'd1;
    end
  end

  // Blink phase flips every BLINK_DIV cycles regardless of what the scan is doing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + 32'd1;
    end
  end

  seg_font u_font (
    .nibble  (cur_nib),
    .pattern (font_pat)
  );

  // Decide whether the current digit is lit and build its anode/segment drive
  always_comb begin
    cur_nib = dig_q[{idx_q, 2'b00} +: 4];
    lit     = (state_q == ST_SHOW) && en_q[idx_q] && !(blink_q[idx_q] && blink_phase_q);
    seg_nxt = 8'hFF;
    an_nxt  = 4'hF;
    if (lit) begin
      seg_nxt = {~dp_q[idx_q], font_pat};
      an_nxt  = ~(4'b0001 << idx_q);
    end
  end

  // Register the pin drive so anode and segment edges line up glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 8'hFF;
      an  <= 4'hF;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_segment_display.sv
// Bench for segment_display with short timing parameters.
// Reference model derives expected drive from the cycle count since reset.
// Inputs are driven 1 time unit after the rising edge, outputs sampled there too.
module tb_segment_display;

  localparam int R      = 8;
  localparam int D      = 2;
  localparam int B      = 64;
  localparam int SLOT   = R + D;
  localparam int PERIOD = 4 * SLOT;

  localparam logic [7:0] FONT8 [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  en_in = '0;
  logic [3:0]  blink_in = '0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  // Model state: edges since reset release and the values the DUT should hold
  int          k = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp = '0, m_en = '0, m_bl = '0;

  typedef struct {
    logic [15:0]      dig;
    logic [3:0]       dp;
    logic [3:0]       en;
    logic [3:0]       bl;
    logic [3:0][7:0]  eseg;
  } vec_t;
  vec_t tbl [6];

  segment_display #(.REFRESH_DIV(R), .DEAD_CYCLES(D), .BLINK_DIV(B)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .digits_in (digits_in),
    .dp_in     (dp_in),
    .en_in     (en_in),
    .blink_in  (blink_in),
    .load      (load),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  // Expected drive given kk edges of scan history and the held request
  task automatic model_out(input int kk, input logic [15:0] d, input logic [3:0] dp,
                           input logic [3:0] en, input logic [3:0] bl,
                           output logic [7:0] es, output logic [3:0] ea);
    int p, slot;
    bit show, phase;
    logic [3:0] nib;
    logic [7:0] glyph;
    p     = kk % PERIOD;
    slot  = p / SLOT;
    show  = (p % SLOT) >= D;
    phase = ((kk / B) % 2) == 1;
    es = 8'hFF;
    ea = 4'hF;
    if (show && en[slot] && !(bl[slot] && phase)) begin
      nib   = d[slot*4 +: 4];
      glyph = FONT8[nib];
      es    = {~dp[slot], glyph[6:0]};
      ea[slot] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [7:0] es, input logic [3:0] ea);
    checks++;
    if (an !== ea || seg !== es) begin
      errors++;
      $display("FAIL %s k=%0d: an=%h seg=%h, expected an=%h seg=%h", name, k, an, seg, ea, es);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock: predict from pre-edge model state, then absorb a sampled load
  task automatic tick(input bit chk);
    logic [7:0] es;
    logic [3:0] ea;
    @(posedge clk);
    model_out(k, m_dig, m_dp, m_en, m_bl, es, ea);
    if (load) begin
      m_dig = digits_in; m_dp = dp_in; m_en = en_in; m_bl = blink_in;
    end
    k++;
    #1;
    if (chk) check("model", es, ea);
  endtask

  task automatic do_reset();
    load  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset_async", 8'hFF, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    m_dig = '0; m_dp = '0; m_en = '0; m_bl = '0;
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en,
                        input logic [3:0] bl);
    digits_in = d; dp_in = dp; en_in = en; blink_in = bl; load = 1'b1;
  endtask

  // Continuous safety monitor: one anode at most, dark means blank segments,
  // and a change of lit digit needs at least D dark cycles before it
  logic [3:0] last_lit = 4'hF;
  int         dark_run = 1000;
  always @(negedge clk) begin
    checks++;
    if ($countones(~an) > 1 || (an == 4'hF && seg != 8'hFF)) begin
      errors++;
      $display("FAIL monitor_onehot: an=%b seg=%h", an, seg);
    end
    if (an == 4'hF) begin
      dark_run++;
    end else begin
      if (last_lit != 4'hF && an != last_lit && dark_run < D) begin
        errors++;
        $display("FAIL monitor_gap: an=%b after %0d dark, expected >= %0d", an, dark_run, D);
      end
      last_lit = an;
      dark_run = 0;
    end
  end

  initial begin
    int lit_cnt;
    logic [3:0] first_an;

    tbl[0] = '{16'h1234, 4'b0000, 4'hF,    4'h0, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    tbl[1] = '{16'h1234, 4'b0000, 4'b0101, 4'h0, {8'hFF, 8'hA4, 8'hFF, 8'h99}};
    tbl[2] = '{16'h00F0, 4'b0010, 4'hF,    4'h0, {8'hC0, 8'hC0, 8'h0E, 8'hC0}};
    tbl[3] = '{16'h89AB, 4'b1001, 4'hF,    4'h0, {8'h00, 8'h90, 8'h88, 8'h03}};
    tbl[4] = '{16'hCDEF, 4'b0000, 4'hF,    4'h0, {8'hC6, 8'hA1, 8'h86, 8'h8E}};
    tbl[5] = '{16'h5670, 4'b1000, 4'b1000, 4'h0, {8'h12, 8'hFF, 8'hFF, 8'hFF}};

    #2;
    // Idle after reset: dark with no load
    do_reset();
    lit_cnt = 0;
    repeat (200) begin
      tick(1'b1);
      if (an != 4'hF || seg != 8'hFF) lit_cnt++;
    end
    check_int("idle_dark", lit_cnt, 0);

    // Table: one load right after reset, mid-slot probes of each digit
    for (int v = 0; v < 6; v++) begin
      logic [3:0] ea;
      do_reset();
      set_in(tbl[v].dig, tbl[v].dp, tbl[v].en, tbl[v].bl);
      tick(1'b1);
      load = 1'b0;
      while (k < 50) begin
        tick(1'b1);
        for (int i = 0; i < 4; i++) begin
          if (k == SLOT * i + 6) begin
            ea = 4'hF;
            if (tbl[v].eseg[i] != 8'hFF) ea[i] = 1'b0;
            check($sformatf("vec%0d_dig%0d", v, i), tbl[v].eseg[i], ea);
          end
        end
      end
    end

    // Blink on digit 0 across both phases
    do_reset();
    set_in(16'h1234, 4'h0, 4'hF, 4'b0001);
    tick(1'b1);
    load = 1'b0;
    while (k < 200) begin
      tick(1'b1);
      if (k == 46 || k == 166) check("blink_on", 8'h99, 4'b1110);
      if (k == 86 || k == 126) check("blink_off", 8'hFF, 4'hF);
    end

    // Back-to-back loads: the second one is what shows
    do_reset();
    set_in(16'hAAAA, 4'h0, 4'hF, 4'h0);
    tick(1'b1);
    set_in(16'h1234, 4'h0, 4'hF, 4'h0);
    tick(1'b1);
    load = 1'b0;
    while (k < 12) begin
      tick(1'b1);
      if (k == 6) check("last_load_wins", 8'h99, 4'b1110);
    end

    // Load in the middle of a lit slot: new glyph next cycle, slot timing intact
    do_reset();
    set_in(16'h1234, 4'h0, 4'hF, 4'h0);
    tick(1'b1);
    load = 1'b0;
    while (k < 5) tick(1'b1);
    set_in(16'h0008, 4'h0, 4'hF, 4'h0);
    tick(1'b1);
    load = 1'b0;
    check("midshow_old", 8'h99, 4'b1110);
    tick(1'b1);
    check("midshow_new", 8'h80, 4'b1110);
    while (k < 11) begin
      tick(1'b1);
      if (k == 10) check("midshow_slot_end", 8'h80, 4'b1110);
      if (k == 11) check("midshow_dead", 8'hFF, 4'hF);
    end

    // Reset in the middle of digit 2, then first lit slot must be digit 0
    do_reset();
    set_in(16'h1234, 4'h0, 4'hF, 4'h0);
    tick(1'b1);
    load = 1'b0;
    while (k < 26) tick(1'b1);
    check("pre_reset_dig2", 8'hA4, 4'b1011);
    do_reset();
    set_in(16'h1234, 4'h0, 4'hF, 4'h0);
    tick(1'b1);
    load = 1'b0;
    first_an = 4'hF;
    repeat (60) begin
      tick(1'b1);
      if (first_an == 4'hF && an != 4'hF) first_an = an;
    end
    check_int("first_lit_after_reset", int'(first_an), int'(4'b1110));

    // Random requests and load timing against the model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      repeat (300) begin
        if ($urandom_range(0, 5) == 0)
          set_in(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        else
          load = 1'b0;
        tick(1'b1);
      end
      load = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
